// File: rtl/clk_div_multi_if.sv
// clk_div_multi_if: control/status bundle for the multi-channel clock divider.
//   i_clk_en      per-channel enable
//   i_div_ratio   per-channel ratio, channel c at [c*DIV_BITS +: DIV_BITS]
//   i_sync        one-cycle re-phase pulse shared by all channels
//   o_div_clk     divided clock per channel
//   o_period_tick one-cycle pulse with each divided-clock rising edge
//   o_active      channel is dividing (not idle, not bypassed)
interface clk_div_multi_if #(
   parameter int DIV_BITS = 8,
   parameter int NUM_CH   = 2
);
   logic [NUM_CH-1:0]          i_clk_en;
   logic [NUM_CH*DIV_BITS-1:0] i_div_ratio;
   logic                       i_sync;
   logic [NUM_CH-1:0]          o_div_clk;
   logic [NUM_CH-1:0]          o_period_tick;
   logic [NUM_CH-1:0]          o_active;

   modport master (
      output i_clk_en, i_div_ratio, i_sync,
      input  o_div_clk, o_period_tick, o_active
   );

   modport slave (
      input  i_clk_en, i_div_ratio, i_sync,
      output o_div_clk, o_period_tick, o_active
   );
endinterface

// File: rtl/clk_div_multi.sv
// clk_div_multi: NUM_CH independent programmable integer clock dividers.
// Each channel divides i_ref_clk by its latched ratio R (low ceil(R/2),
// high floor(R/2)); ratio changes land only at period boundaries.
// Ports:
//   i_ref_clk  reference clock, all state on its rising edge
//   i_rst      asynchronous active-high reset
//   bus        clk_div_multi_if.slave (enables, ratios, sync, outputs)

// One divider channel.
module clk_div_ch #(
   parameter int DIV_BITS = 8
) (
   input  logic                ref_clk,
   input  logic                rst,
   input  logic                en,
   input  logic                sync,
   input  logic [DIV_BITS-1:0] ratio,
   output logic                div_clk,
   output logic                tick,
   output logic                active
);
   typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

   state_t              state;
   logic [DIV_BITS-1:0] cnt;
   logic [DIV_BITS-1:0] r_act;
   logic                div_q;

   // ratio >= 2 means "divide"; 0/1 mean bypass
   logic                live_ok;
   logic [DIV_BITS-1:0] lo_len;
   logic [DIV_BITS-1:0] hi_len;

   assign live_ok = |ratio[DIV_BITS-1:1];
   // ceil(R/2) written so R = 2^DIV_BITS-1 does not overflow
   assign lo_len  = r_act - (r_act >> 1);
   assign hi_len  = r_act >> 1;

   always_ff @(posedge ref_clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         r_act  <= '0;
         div_q  <= 1'b0;
         tick   <= 1'b0;
         active <= 1'b0;
      end else if (!en) begin
         state  <= IDLE;
         cnt    <= '0;
         div_q  <= 1'b0;
         tick   <= 1'b0;
         active <= 1'b0;
      end else if (state == IDLE || sync) begin
         // start (from IDLE) or re-phase (running channel): both act as e0
         tick <= 1'b0;
         cnt  <= '0;
         div_q <= 1'b0;
         if (live_ok) begin
            state  <= LOW;
            r_act  <= ratio;
            active <= 1'b1;
         end else begin
            state  <= IDLE;
            active <= 1'b0;
         end
      end else if (state == LOW) begin
         if (cnt == lo_len - 1'b1) begin
            state <= HIGH;
            div_q <= 1'b1;
            tick  <= 1'b1;
            cnt   <= '0;
         end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
         end
      end else begin
         tick <= 1'b0;
         if (cnt == hi_len - 1'b1) begin
            // period boundary: the only point where a new ratio is taken
            div_q <= 1'b0;
            cnt   <= '0;
            if (live_ok) begin
               state <= LOW;
               r_act <= ratio;
            end else begin
               state  <= IDLE;
               active <= 1'b0;
            end
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // Bypass passes the reference clock straight through; disabled is held low.
   always_comb begin
      div_clk = 1'b0;
      if (en) begin
         if (state == IDLE && !live_ok) div_clk = ref_clk;
         else                           div_clk = div_q;
      end
   end
endmodule

module clk_div_multi #(
   parameter int DIV_BITS = 8,
   parameter int NUM_CH   = 2
) (
   input  logic           i_ref_clk,
   input  logic           i_rst,
   clk_div_multi_if.slave bus
);
   logic [NUM_CH-1:0] div_clk;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] active;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      clk_div_ch #(.DIV_BITS(DIV_BITS)) u_ch (
         .ref_clk (i_ref_clk),
         .rst     (i_rst),
         .en      (bus.i_clk_en[c]),
         .sync    (bus.i_sync),
         .ratio   (bus.i_div_ratio[c*DIV_BITS +: DIV_BITS]),
         .div_clk (div_clk[c]),
         .tick    (tick[c]),
         .active  (active[c])
      );
   end

   assign bus.o_div_clk     = div_clk;
   assign bus.o_period_tick = tick;
   assign bus.o_active      = active;
endmodule

// File: tb/tb_clk_div_multi.sv
module tb_clk_div_multi;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   clk_div_multi_if #(.DIV_BITS(8), .NUM_CH(2)) bus ();

   clk_div_multi #(.DIV_BITS(8), .NUM_CH(2)) dut (
      .i_ref_clk (clk),
      .i_rst     (rst),
      .bus       (bus)
   );

   // steady-run vectors: channel, ratio, expected low/high phase lengths, cycles
   typedef struct {
      int ch;
      int r;
      int exp_low;
      int exp_high;
      int cycles;
   } run_t;

   // static vectors that never start a channel: enables, ratios, outputs
   typedef struct {
      logic [1:0] en;
      logic [7:0] r0;
      logic [7:0] r1;
      logic [1:0] exp_hi;   // o_div_clk while ref clock high
      logic [1:0] exp_lo;   // o_div_clk while ref clock low
      logic [1:0] exp_act;
   } byp_t;

   run_t runs [5];
   byp_t byps [4];

   task automatic chk(input string nm, input int c, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s ch%0d got %0d expected %0d at %0t", nm, c, act, exp, $time);
      end
   endtask

   // sample 1 time unit after the rising edge (ref clock is high there)
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // k = edges since e0; low for lo cycles then high for hi cycles
   task automatic expect_phase(input string nm, input int c, input int lo, input int hi,
                               input int k);
      int pos;
      pos = k % (lo + hi);
      chk({nm, "_div"},  c, int'(bus.o_div_clk[c]),     int'(pos >= lo));
      chk({nm, "_tick"}, c, int'(bus.o_period_tick[c]), int'(pos == lo));
      chk({nm, "_act"},  c, int'(bus.o_active[c]),      1);
   endtask

   task automatic do_reset();
      rst             = 1'b1;
      bus.i_clk_en    = '0;
      bus.i_div_ratio = '0;
      bus.i_sync      = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      runs[0] = '{ch: 0, r: 4,   exp_low: 2,   exp_high: 2,   cycles: 12};
      runs[1] = '{ch: 1, r: 5,   exp_low: 3,   exp_high: 2,   cycles: 15};
      runs[2] = '{ch: 0, r: 2,   exp_low: 1,   exp_high: 1,   cycles: 6};
      runs[3] = '{ch: 1, r: 3,   exp_low: 2,   exp_high: 1,   cycles: 9};
      runs[4] = '{ch: 1, r: 255, exp_low: 128, exp_high: 127, cycles: 520};

      byps[0] = '{en: 2'b11, r0: 8'd1, r1: 8'd0, exp_hi: 2'b11, exp_lo: 2'b00, exp_act: 2'b00};
      byps[1] = '{en: 2'b01, r0: 8'd0, r1: 8'd1, exp_hi: 2'b01, exp_lo: 2'b00, exp_act: 2'b00};
      byps[2] = '{en: 2'b00, r0: 8'd1, r1: 8'd1, exp_hi: 2'b00, exp_lo: 2'b00, exp_act: 2'b00};
      byps[3] = '{en: 2'b10, r0: 8'd4, r1: 8'd1, exp_hi: 2'b10, exp_lo: 2'b00, exp_act: 2'b00};

      // reset state
      do_reset();
      chk("rst_div",  0, int'(bus.o_div_clk),     0);
      chk("rst_tick", 0, int'(bus.o_period_tick), 0);
      chk("rst_act",  0, int'(bus.o_active),      0);

      // steady division
      foreach (runs[i]) begin
         do_reset();
         bus.i_clk_en[runs[i].ch]                  = 1'b1;
         bus.i_div_ratio[runs[i].ch*8 +: 8]        = 8'(runs[i].r);
         for (int k = 0; k < runs[i].cycles; k++) begin
            step();
            expect_phase("run", runs[i].ch, runs[i].exp_low, runs[i].exp_high, k);
         end
         chk("run_other_idle", 1 - runs[i].ch, int'(bus.o_active[1 - runs[i].ch]), 0);
      end

      // bypass / disabled
      do_reset();
      foreach (byps[i]) begin
         bus.i_clk_en    = byps[i].en;
         bus.i_div_ratio = {byps[i].r1, byps[i].r0};
         step();
         chk("byp_hi",  i, int'(bus.o_div_clk), int'(byps[i].exp_hi));
         chk("byp_act", i, int'(bus.o_active),  int'(byps[i].exp_act));
         #5;
         chk("byp_lo",  i, int'(bus.o_div_clk), int'(byps[i].exp_lo));
      end

      // ratio 4 -> 6 one cycle after a rising edge: current period still 4
      do_reset();
      bus.i_clk_en[0]       = 1'b1;
      bus.i_div_ratio[7:0]  = 8'd4;
      for (int k = 0; k < 4; k++) begin
         step();
         expect_phase("chg4", 0, 2, 2, k);
         if (k == 3) bus.i_div_ratio[7:0] = 8'd6;
      end
      for (int k = 0; k < 12; k++) begin
         step();
         expect_phase("chg6", 0, 3, 3, k);
      end

      // ratio 4 -> 1 mid-period: bypass only after the period ends
      do_reset();
      bus.i_clk_en[0]      = 1'b1;
      bus.i_div_ratio[7:0] = 8'd4;
      for (int k = 0; k < 4; k++) begin
         step();
         expect_phase("tobyp", 0, 2, 2, k);
         if (k == 1) bus.i_div_ratio[7:0] = 8'd1;
      end
      step();
      chk("tobyp_hi",  0, int'(bus.o_div_clk[0]), 1);
      chk("tobyp_act", 0, int'(bus.o_active[0]),  0);
      #5;
      chk("tobyp_lo",  0, int'(bus.o_div_clk[0]), 0);

      // sync re-phases ch0 (R=3) and ch1 (R=6)
      do_reset();
      bus.i_clk_en[1]       = 1'b1;
      bus.i_div_ratio[15:8] = 8'd6;
      step();
      step();
      bus.i_clk_en[0]       = 1'b1;
      bus.i_div_ratio[7:0]  = 8'd3;
      for (int k = 0; k < 4; k++) step();
      bus.i_sync = 1'b1;
      step();
      bus.i_sync = 1'b0;
      for (int k = 0; k < 14; k++) begin
         if (k > 0) step();
         expect_phase("sync", 0, 2, 1, k);
         expect_phase("sync", 1, 3, 3, k);
      end

      // disable mid-HIGH
      do_reset();
      bus.i_clk_en[0]      = 1'b1;
      bus.i_div_ratio[7:0] = 8'd4;
      for (int k = 0; k < 3; k++) begin
         step();
         expect_phase("dis", 0, 2, 2, k);
      end
      bus.i_clk_en[0] = 1'b0;
      step();
      chk("dis_div",  0, int'(bus.o_div_clk[0]),     0);
      chk("dis_act",  0, int'(bus.o_active[0]),      0);
      chk("dis_tick", 0, int'(bus.o_period_tick[0]), 0);

      // async reset mid-LOW, then restart as at e0 with enable held
      do_reset();
      bus.i_clk_en[0]      = 1'b1;
      bus.i_div_ratio[7:0] = 8'd4;
      for (int k = 0; k < 5; k++) begin
         step();
         expect_phase("arst", 0, 2, 2, k);
      end
      rst = 1'b1;
      #1;
      chk("arst_div",  0, int'(bus.o_div_clk[0]), 0);
      chk("arst_act",  0, int'(bus.o_active[0]),  0);
      step();
      rst = 1'b0;
      for (int k = 0; k < 9; k++) begin
         step();
         expect_phase("arst_re", 0, 2, 2, k);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
